// File: rtl/cla_accumulate_stage.sv
// cla_accumulate_stage: valid/ready burst accumulator built around a carry-lookahead adder
module cla_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         of
);
    logic [N-1:0] p, g;
    logic [N:0]   c;
    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = cin;
    for (genvar k = 0; k < N / 4; k++) begin : grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end
    assign sum  = p ^ c[N-1:0];
    assign cout = c[N];
    assign of   = c[N] ^ c[N-1];
endmodule

module cla_accumulate_stage #(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_of,
    output logic [CW-1:0] out_carries,
    output logic [CW-1:0] out_beats
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t        state, state_nx;
    logic [N-1:0]  acc, sum;
    logic          cout, of, of_sticky, take, flush;
    logic [CW-1:0] carries, beats;

    assign take  = in_valid && in_ready;
    assign flush = (state == DONE) && out_ready;

    cla_adder #(.N(N)) u_cla (
        .a(acc), .b(in_data), .cin(1'b0), .sum(sum), .cout(cout), .of(of)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // a beat moves to ACCUM or DONE on last; DONE leaves on result handshake
    always_comb begin
        state_nx = state;
        if (take)       state_nx = in_last ? DONE : ACCUM;
        else if (flush) state_nx = IDLE;
    end

    // handshake outputs depend only on state
    always_comb begin
        in_ready  = state != DONE;
        out_valid = state == DONE;
    end

    // accumulator and flags: cleared on reset or result handshake, updated on accepted beats
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc       <= '0;
            of_sticky <= 1'b0;
            carries   <= '0;
            beats     <= '0;
        end else if (take) begin
            acc       <= sum;
            of_sticky <= of_sticky | of;
            carries   <= (&carries) ? carries : carries + CW'(cout);
            beats     <= (&beats) ? beats : beats + 1'b1;
        end
    end

    assign out_sum     = acc;
    assign out_of      = of_sticky;
    assign out_carries = carries;
    assign out_beats   = beats;
endmodule

// File: tb/tb_cla_accumulate_stage.sv
// tb_cla_accumulate_stage: randomized and directed checks against an arithmetic model
module tb_cla_accumulate_stage;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_last = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_sum, out_sum2;
    logic        out_of, out_of2;
    logic [7:0]  out_carries, out_beats;
    logic [1:0]  out_car2, out_beats2;
    int total = 0, bad = 0;
    logic [31:0] q[$];
    logic [31:0] m_acc;
    logic        m_of;
    int          m_nc, m_nb;

    always #5 clk = ~clk;

    cla_accumulate_stage #(.N(32), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_of(out_of),
        .out_carries(out_carries), .out_beats(out_beats)
    );

    cla_accumulate_stage #(.N(32), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_of(out_of2),
        .out_carries(out_car2), .out_beats(out_beats2)
    );

    function automatic void model_add(input logic [31:0] x);
        logic [32:0] t;
        t = {1'b0, m_acc} + {1'b0, x};
        m_of = m_of | ((m_acc[31] == x[31]) && (t[31] != m_acc[31]));
        m_nc += int'(t[32]);
        m_nb++;
        m_acc = t[31:0];
    endfunction

    function automatic void model_clear();
        m_acc = 0; m_of = 0; m_nc = 0; m_nb = 0;
    endfunction

    function automatic int sat(input int v, input int lim);
        return v > lim ? lim : v;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // drives q as one burst with optional idle gaps, checks result, then handshakes it away
    task automatic do_burst(input string name, input int gap_pct);
        model_clear();
        foreach (q[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 0; in_data = $urandom; in_last = $urandom_range(1);
                step();
                total++;
                if (out_sum !== m_acc || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle: sum=%h valid=%b want sum=%h valid=0", name, out_sum, out_valid, m_acc);
                end
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s in_ready: got %b want 1", name, in_ready);
            end
            in_valid = 1; in_data = q[i]; in_last = (i == q.size() - 1);
            model_add(q[i]);
            step();
            in_valid = 0; in_last = 0;
        end
        total++;
        if (out_valid !== 1 || in_ready !== 0 || out_sum !== m_acc || out_of !== m_of ||
            out_carries !== 8'(sat(m_nc, 255)) || out_beats !== 8'(sat(m_nb, 255))) begin
            bad++;
            $display("FAIL %s result: v=%b r=%b sum=%h of=%b c=%0d b=%0d want v=1 r=0 sum=%h of=%b c=%0d b=%0d",
                     name, out_valid, in_ready, out_sum, out_of, out_carries, out_beats,
                     m_acc, m_of, sat(m_nc, 255), sat(m_nb, 255));
        end
        total++;
        if (out_valid2 !== 1 || out_sum2 !== m_acc || out_of2 !== m_of ||
            out_car2 !== 2'(sat(m_nc, 3)) || out_beats2 !== 2'(sat(m_nb, 3))) begin
            bad++;
            $display("FAIL %s result_cw2: v=%b sum=%h of=%b c=%0d b=%0d want v=1 sum=%h of=%b c=%0d b=%0d",
                     name, out_valid2, out_sum2, out_of2, out_car2, out_beats2,
                     m_acc, m_of, sat(m_nc, 3), sat(m_nb, 3));
        end
        out_ready = 1;
        step();
        out_ready = 0;
        total++;
        if (out_valid !== 0 || in_ready !== 1 || out_sum !== 0 || out_of !== 0 ||
            out_carries !== 0 || out_beats !== 0 || out_car2 !== 0 || out_beats2 !== 0) begin
            bad++;
            $display("FAIL %s drain: v=%b r=%b sum=%h of=%b c=%0d b=%0d want idle zeros",
                     name, out_valid, in_ready, out_sum, out_of, out_carries, out_beats);
        end
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0;
        total++;
        if (out_valid !== 0 || in_ready !== 1 || out_sum !== 0 || out_of !== 0 ||
            out_carries !== 0 || out_beats !== 0) begin
            bad++;
            $display("FAIL reset: v=%b r=%b sum=%h of=%b c=%0d b=%0d want 0 1 0 0 0 0",
                     out_valid, in_ready, out_sum, out_of, out_carries, out_beats);
        end
    endtask

    task automatic test_directed();
        q = '{32'd5, 32'd7, 32'hFFFF_FFF0};          do_burst("plan_wrap", 0);
        q = '{32'h7FFF_FFFF, 32'h1};                 do_burst("plan_of", 0);
        q = '{32'd1, 32'd1};                         do_burst("plan_of_clear", 0);
        q = '{32'hFFFF_FFFF, 32'h1};                 do_burst("plan_neg1", 0);
        q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        do_burst("plan_sat", 0);
        q = '{32'h8000_0000, 32'h8000_0000};         do_burst("plan_negof", 0);
        q = '{32'hDEAD_BEEF};                        do_burst("single", 0);
        total++;
        if (m_acc !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_model: got %h want deadbeef", m_acc);
        end
    endtask

    task automatic test_backpressure();
        q = '{32'd1, 32'd2};
        model_clear();
        foreach (q[i]) begin
            in_valid = 1; in_data = q[i]; in_last = (i == 1);
            model_add(q[i]); step();
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 32'd99; in_last = 1;
            step();
            total++;
            if (in_ready !== 0 || out_valid !== 1 || out_sum !== 32'd3 || out_beats !== 8'd2) begin
                bad++;
                $display("FAIL backpressure: r=%b v=%b sum=%h b=%0d want 0 1 3 2", in_ready, out_valid, out_sum, out_beats);
            end
        end
        in_valid = 0; in_last = 0; out_ready = 1;
        step();
        out_ready = 0;
        total++;
        if (in_ready !== 1 || out_valid !== 0 || out_sum !== 0 || out_beats !== 0) begin
            bad++;
            $display("FAIL bp_release: r=%b v=%b sum=%h b=%0d want 1 0 0 0", in_ready, out_valid, out_sum, out_beats);
        end
    endtask

    task automatic test_rst_mid();
        in_valid = 1; in_data = 5; in_last = 0; step();
        in_data = 7; step();
        in_valid = 0;
        total++;
        if (out_sum !== 32'd12 || out_beats !== 8'd2) begin
            bad++;
            $display("FAIL mid_acc: sum=%h b=%0d want c 2", out_sum, out_beats);
        end
        rst = 1; step(); rst = 0;
        total++;
        if (out_sum !== 0 || out_beats !== 0 || out_carries !== 0 || out_of !== 0 || out_valid !== 0 || in_ready !== 1) begin
            bad++;
            $display("FAIL mid_rst: sum=%h b=%0d c=%0d of=%b v=%b r=%b want zeros r=1",
                     out_sum, out_beats, out_carries, out_of, out_valid, in_ready);
        end
        q = '{32'd3}; do_burst("after_rst", 0);
        q = '{32'd4, 32'd4}; do_burst("pre_done_rst", 0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 30; b++) begin
            q.delete();
            for (int i = 0; i <= int'($urandom_range(7)); i++)
                q.push_back($urandom_range(3) == 0 ? 32'h7FFF_FFF0 + $urandom_range(31) : $urandom);
            do_burst("random", 30);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
